// File: rtl/stream_fmt_pkg.sv
// Shared types and helpers for the stochastic bitstream format converter.
package stream_fmt_pkg;

  typedef enum logic {
    BI2UNI = 1'b0,
    UNI2BI = 1'b1
  } fmt_mode_t;

  // Accumulator midpoint: the "zero difference" level for a DEP-bit accumulator.
  function automatic int mid_val(input int dep);
    return 1 << (dep - 1);
  endfunction

endpackage

// File: rtl/stream_fmt_lane.sv
// One converter channel: clamped difference accumulator with mode register
// and sticky saturation flag.
module stream_fmt_lane
  import stream_fmt_pkg::*;
#(
  parameter int DEP = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic i_mode,
  input  logic i_en,
  input  logic i_in,
  output logic o_out,
  output logic o_sat
);

  localparam logic [DEP-1:0]        MID  = DEP'(mid_val(DEP));
  localparam logic signed [DEP+1:0] ZERO = '0;
  localparam logic signed [DEP+1:0] ONE  = (DEP+2)'(1);
  localparam logic signed [DEP+1:0] TWO  = (DEP+2)'(2);
  localparam logic signed [DEP+1:0] MAXV = $signed({2'b00, {DEP{1'b1}}});

  logic [DEP-1:0]        r_acc;
  fmt_mode_t             r_mode;
  logic                  r_sat;

  logic                  w_gt;
  logic signed [DEP+1:0] w_acc_ext;
  logic signed [DEP+1:0] w_nxt;
  logic [DEP-1:0]        w_acc_clamped;
  logic                  w_clamp;

  assign w_gt      = (r_acc > MID);
  assign w_acc_ext = $signed({2'b00, r_acc});
  assign o_out     = i_en & w_gt;
  assign o_sat     = r_sat;

  // The feedback term uses w_gt: updates only happen with i_en high, where it equals o_out.
  always_comb begin
    w_nxt         = w_acc_ext;
    w_acc_clamped = r_acc;
    w_clamp       = 1'b0;
    if (r_mode == BI2UNI) begin
      w_nxt = w_acc_ext + (i_in ? ONE : -ONE) - (w_gt ? ONE : ZERO);
    end else begin
      w_nxt = w_acc_ext + (i_in ? TWO : ONE) - (w_gt ? TWO : ZERO);
    end
    if (w_nxt < ZERO) begin
      w_acc_clamped = '0;
      w_clamp       = 1'b1;
    end else if (w_nxt > MAXV) begin
      w_acc_clamped = '1;
      w_clamp       = 1'b1;
    end else begin
      w_acc_clamped = w_nxt[DEP-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= MID;
      r_mode <= BI2UNI;
      r_sat  <= 1'b0;
    end else if (clr) begin
      r_acc  <= MID;
      r_mode <= fmt_mode_t'(i_mode);
      r_sat  <= 1'b0;
    end else if (i_en) begin
      r_acc  <= w_acc_clamped;
      r_sat  <= r_sat | w_clamp;
    end
  end

endmodule

// File: rtl/stream_fmt_conv.sv
// Multi-channel stochastic bitstream format converter: CH independent lanes
// sharing clock, reset and clear.
module stream_fmt_conv
  import stream_fmt_pkg::*;
#(
  parameter int CH  = 4,
  parameter int DEP = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [CH-1:0] mode,
  input  logic [CH-1:0] en,
  input  logic [CH-1:0] in,
  output logic [CH-1:0] out,
  output logic [CH-1:0] sat
);

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_lane
      stream_fmt_lane #(
        .DEP(DEP)
      ) u_lane (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .i_mode(mode[gi]),
        .i_en  (en[gi]),
        .i_in  (in[gi]),
        .o_out (out[gi]),
        .o_sat (sat[gi])
      );
    end
  endgenerate

endmodule
